mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/byte_bank.sv | 31 +++
 rtl/mem_access_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: types shared by the memory access controller and its bench.
//   mode_e   - access size encoding on the 'mode' port
//   state_e  - controller FSM state, also visible on the state_dbg port
//   mode_bytes() - number of bytes moved by one access of a given size
package mem_access_pkg;

    typedef enum logic [1:0] {
        MODE_BYTE = 2'd0,
        MODE_HALF = 2'd1,
        MODE_FULL = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int unsigned WAIT_CNT_W = 4;

    // A reserved mode moves a full word; its access is rejected anyway.
    function automatic int unsigned mode_bytes(input mode_e m, input int unsigned lanes);
        case (m)
            MODE_BYTE: return 1;
            MODE_HALF: return 2;
            default:   return lanes;
        endcase
    endfunction

endpackage

// File: rtl/byte_bank.sv
// byte_bank: one byte-wide synchronous RAM lane.
//   clk  - clock
//   we   - write enable, din is stored at addr on the rising edge
//   addr - row address
//   din  - write byte
//   dout - registered read of addr (read-before-write on a same-edge write)
// Contents are not reset.
module byte_bank #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] dout_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout_q <= mem_q[addr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-laned, big-endian memory with a small access FSM
// (IDLE -> ACCESS -> WAIT -> DONE). An access starts on a 0->1 edge of the
// registered enable; moc pulses 3 + WAIT_CYCLES cycles after the cycle in
// which enable rose.
//
// Ports
//   clk, reset          - clock, asynchronous active-high reset
//   enable              - request strobe (edge triggered)
//   read_write          - 1 read, 0 write
//   address             - byte address
//   mode                - 0 byte, 1 halfword, 2 full width, 3 reserved
//   sign_ext            - sign-extend byte/halfword reads
//   data_in             - right-justified write data
//   data_out            - right-justified read data, held until next good read
//   moc                 - one-cycle completion pulse
//   busy                - high from accept through the moc cycle
//   err                 - pulses with moc when the access was rejected
//   state_dbg           - current FSM state
//
// Build option: MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned halfword and
// full-width accesses instead of aligning them down.
//
// Handshake: a request is one enable rise with all request fields stable at
// the accept edge; completion is the single-cycle moc pulse. A request made
// while busy is dropped, and enable must be seen low before it can rise again.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned LANES       = 4,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 read_write,
    input  logic [ADDR_W-1:0]    address,
    input  logic [1:0]           mode,
    input  logic                 sign_ext,
    input  logic [8*LANES-1:0]   data_in,
    output logic [8*LANES-1:0]   data_out,
    output logic                 moc,
    output logic                 busy,
    output logic                 err,
    output state_e               state_dbg
);

    localparam int unsigned DW     = 8 * LANES;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned ROW_W  = ADDR_W - LANE_W;
    localparam int unsigned DEPTH  = 1 << ROW_W;

    state_e                 state_q, state_d;
    logic                   enable_q, enable_d;
    logic                   en_prev_q, en_prev_d;
    logic                   armed_q, armed_d;
    logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    mode_e                  mode_q, mode_d;
    logic                   sext_q, sext_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic [DW-1:0]          data_out_q, data_out_d;
    logic                   moc_q, moc_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    logic                   rise;
    logic                   reject;
    logic [ADDR_W-1:0]      base_addr;
    logic [LANE_W-1:0]      start_lane;
    logic [LANE_W:0]        nbytes;
    logic [LANE_W-1:0]      k_l;
    logic [LANE_W-1:0]      pos_l;
    logic [LANES-1:0]       lane_sel;
    logic [LANES-1:0]       lane_we;
    logic [7:0]             lane_wdata [LANES];
    logic [7:0]             lane_rdata [LANES];
    logic [ROW_W-1:0]       bank_addr;
    logic [DW-1:0]          rd_raw;
    logic [DW-1:0]          rd_ext;

    // ------------------------------------------------------------------
    // Lane mapping for the captured request. Aligned accesses never cross
    // a row, so every selected lane shares one row address. Big-endian:
    // the lane at the lowest address carries the most-significant byte.
    // ------------------------------------------------------------------
    always_comb begin
        base_addr = addr_q;
        if (mode_q == MODE_HALF) begin
            base_addr[0] = 1'b0;
        end else if (mode_q == MODE_FULL || mode_q == MODE_RSVD) begin
            base_addr[LANE_W-1:0] = '0;
        end
        start_lane = base_addr[LANE_W-1:0];
        nbytes     = (LANE_W+1)'(mode_bytes(mode_q, LANES));

        reject = (mode_q == MODE_RSVD);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        if ((mode_q == MODE_HALF && addr_q[0]) ||
            (mode_q == MODE_FULL && addr_q[LANE_W-1:0] != '0)) begin
            reject = 1'b1;
        end
`endif

        rd_raw = '0;
        k_l    = '0;
        pos_l  = '0;
        for (int i = 0; i < LANES; i++) begin
            k_l           = LANE_W'(i) - start_lane;
            pos_l         = LANE_W'(nbytes - 1'b1) - k_l;
            lane_sel[i]   = (LANE_W'(i) >= start_lane) && ({1'b0, k_l} < nbytes);
            lane_wdata[i] = wdata_q[{pos_l, 3'b000} +: 8];
            lane_we[i]    = (state_q == ACCESS) && !rw_q && !reject && lane_sel[i];
            if (lane_sel[i]) begin
                rd_raw[{pos_l, 3'b000} +: 8] = lane_rdata[i];
            end
        end

        rd_ext = rd_raw;
        if (mode_q == MODE_BYTE) begin
            for (int b = 8; b < DW; b++) begin
                rd_ext[b] = sext_q & rd_raw[7];
            end
        end else if (mode_q == MODE_HALF) begin
            for (int b = 16; b < DW; b++) begin
                rd_ext[b] = sext_q & rd_raw[15];
            end
        end
    end

    // The row read is launched on the accept edge straight from the port
    // address, so the bank outputs are already valid during ACCESS and the
    // result can be registered on any exit into DONE, including WAIT_CYCLES=0.
    // Alignment only clears bits below the lane field, so the row is the same.
    assign bank_addr = (state_q == IDLE) ? address[ADDR_W-1:LANE_W]
                                         : addr_q[ADDR_W-1:LANE_W];

    for (genvar g = 0; g < LANES; g++) begin : g_bank
        byte_bank #(
            .DEPTH (DEPTH),
            .AW    (ROW_W)
        ) u_bank (
            .clk   (clk),
            .we    (lane_we[g]),
            .addr  (bank_addr),
            .din   (lane_wdata[g]),
            .dout  (lane_rdata[g])
        );
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // armed_q blocks an enable that is already high out of reset from
    // counting as an edge; it sets once enable has been seen low.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        enable_d   = enable;
        en_prev_d  = enable_q;
        armed_d    = armed_q | ~enable;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        mode_d     = mode_q;
        sext_d     = sext_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        moc_d      = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q;

        rise = enable_q & ~en_prev_q & armed_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (rise) begin
                    state_d = ACCESS;
                    busy_d  = 1'b1;
                    rw_d    = read_write;
                    mode_d  = mode_e'(mode);
                    sext_d  = sign_ext;
                    addr_d  = address;
                    wdata_d = data_in;
                end
            end
            ACCESS: begin
                if (WAIT_CYCLES == 0) begin
                    state_d = DONE;
                    moc_d   = 1'b1;
                    err_d   = reject;
                    if (rw_q && !reject) begin
                        data_out_d = rd_ext;
                    end
                end else begin
                    state_d = WAIT;
                    cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (cnt_q <= WAIT_CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    moc_d   = 1'b1;
                    err_d   = reject;
                    if (rw_q && !reject) begin
                        data_out_d = rd_ext;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            enable_q   <= 1'b0;
            en_prev_q  <= 1'b0;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            mode_q     <= MODE_BYTE;
            sext_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            moc_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            en_prev_q  <= en_prev_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            mode_q     <= mode_d;
            sext_q     <= sext_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            moc_q      <= moc_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign data_out  = data_out_q;
    assign moc       = moc_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule
